addsub_rr_arbiter: RTL

Round-robin arbiter and sequencer that shares one combinational add/subtract datapath (A, B, Op in; S, C, V out) between two requesters. It accepts one operation at a time with a req/gnt handshake and drives the datapath from held operand registers. It captures S/C/V into result registers and returns them on a shared, tagged result bus. It sits between the two client blocks and the single add/sub instance.

---
 rtl/addsub_rr_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/addsub_rr_arbiter.sv
// addsub_rr_arbiter: two-client round-robin front end for one shared
// combinational add/subtract datapath. One operation at a time:
// grant (IDLE) -> datapath evaluates held operands (EXEC) -> tagged result
// presented for one cycle (RESP).
// Optional grant statistics counters cnt0/cnt1 are built when the macro
// ADDSUB_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for req0/req1; winner chosen and operands latched on exit
// EXEC  | operand regs drive the datapath; S/C/V captured on exit
// RESP  | res_valid high for exactly this cycle
module addsub_rr_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic         op0,
    input  logic         op1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         res_valid,
    output logic         res_id,
    output logic [W-1:0] res_s,
    output logic         res_c,
    output logic         res_v,
    output logic [W-1:0] dp_a,
    output logic [W-1:0] dp_b,
    output logic         dp_op,
    input  logic [W-1:0] dp_s,
    input  logic         dp_c,
    input  logic         dp_v
`ifdef ADDSUB_ARB_STATS_EN
    ,
    output logic [7:0]   cnt0,
    output logic [7:0]   cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   ptr;
    logic   op_id;
    logic   win_id;
    logic   take;
    logic   capture;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; requests only matter while idle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 || req1) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control decode: accept strobe, winner select, result capture strobe
    always_comb begin
        take    = (state == IDLE) && (req0 || req1);
        capture = (state == EXEC);
        // With a single requester it wins outright; a tie goes to ptr
        win_id  = (req0 && req1) ? ptr : req1;
    end

    // Grant pulses, operand/id latch and priority pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            dp_a  <= '0;
            dp_b  <= '0;
            dp_op <= 1'b0;
            op_id <= 1'b0;
            ptr   <= 1'b0;
        end else begin
            gnt0 <= take && !win_id;
            gnt1 <= take && win_id;
            if (take) begin
                dp_a  <= win_id ? a1  : a0;
                dp_b  <= win_id ? b1  : b0;
                dp_op <= win_id ? op1 : op0;
                op_id <= win_id;
                ptr   <= !win_id;
            end
        end
    end

    // Result capture from the datapath; values hold after res_valid drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_s     <= '0;
            res_c     <= 1'b0;
            res_v     <= 1'b0;
        end else begin
            res_valid <= capture;
            if (capture) begin
                res_id <= op_id;
                res_s  <= dp_s;
                res_c  <= dp_c;
                res_v  <= dp_v;
            end
        end
    end

`ifdef ADDSUB_ARB_STATS_EN
    // Per-client grant counters, free-running with natural 8-bit wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= 8'd0;
            cnt1 <= 8'd0;
        end else begin
            if (gnt0) cnt0 <= cnt0 + 8'd1;
            if (gnt1) cnt1 <= cnt1 + 8'd1;
        end
    end
`endif

endmodule
